// File: rtl/fsm_convert_fixed_to_float.sv
// Control sequencer for one fixed-to-float conversion: steps the datapath
// register enables and shifter load, then holds ACK_FF until BEGIN_FSM drops.
module fsm_convert_fixed_to_float #(
  parameter int W         = 8,
  parameter int SHIFT_REF = 26
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         BEGIN_FSM,
  input  logic [W-1:0] Encd,
  input  logic         Bandcomp,
  output logic         EN_REG1,
  output logic         EN_REGmult,
  output logic         LOAD,
  output logic         MS_1,
  output logic         EN_REG2,
  output logic         ACK_FF,
  output logic         BUSY
);

  localparam logic [W-1:0] SHIFT_REF_V = SHIFT_REF[W-1:0];

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD_FIXED = 3'd1,
    ST_DESNORM    = 3'd2,
    ST_ENCODE     = 3'd3,
    ST_DECIDE     = 3'd4,
    ST_SHIFT      = 3'd5,
    ST_STORE      = 3'd6,
    ST_DONE       = 3'd7
  } state_t;

  state_t state_r;
  state_t next_state_s;

  logic en_reg1_s, en_regmult_s, load_s, ms_sel_s, en_reg2_s, ack_s, busy_s;
  logic en_reg1_r, en_regmult_r, load_r, ms_sel_r, en_reg2_r, ack_r, busy_r;

  // Shift direction is resolved inside the datapath from Bandcomp; the FSM never needs it.
  logic bandcomp_unused_s;
  assign bandcomp_unused_s = Bandcomp;

  // Next-state logic: fixed six-step walk from LOAD_FIXED to DONE.
  always_comb begin
    next_state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (BEGIN_FSM) begin
          next_state_s = ST_LOAD_FIXED;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LOAD_FIXED: next_state_s = ST_DESNORM;
      ST_DESNORM:    next_state_s = ST_ENCODE;
      ST_ENCODE:     next_state_s = ST_DECIDE;
      ST_DECIDE:     next_state_s = ST_SHIFT;
      ST_SHIFT:      next_state_s = ST_STORE;
      ST_STORE:      next_state_s = ST_DONE;
      ST_DONE: begin
        if (BEGIN_FSM) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      default:       next_state_s = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with state_r.
  always_comb begin
    en_reg1_s    = 1'b0;
    en_regmult_s = 1'b0;
    load_s       = 1'b0;
    ms_sel_s     = 1'b0;
    en_reg2_s    = 1'b0;
    ack_s        = 1'b0;
    busy_s       = (next_state_s != ST_IDLE);
    case (next_state_s)
      ST_IDLE:       busy_s       = 1'b0;
      ST_LOAD_FIXED: en_reg1_s    = 1'b1;
      ST_DESNORM:    en_regmult_s = 1'b1;
      ST_ENCODE:     busy_s       = 1'b1;
      ST_DECIDE: begin
        load_s   = 1'b1;
        ms_sel_s = 1'b1;
      end
      ST_SHIFT:      busy_s       = 1'b1;
      ST_STORE:      en_reg2_s    = 1'b1;
      ST_DONE:       ack_s        = 1'b1;
      default:       busy_s       = 1'b0;
    endcase
  end

  // State and output registers, cleared synchronously by RST.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= ST_IDLE;
      en_reg1_r    <= 1'b0;
      en_regmult_r <= 1'b0;
      load_r       <= 1'b0;
      ms_sel_r     <= 1'b0;
      en_reg2_r    <= 1'b0;
      ack_r        <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      en_reg1_r    <= en_reg1_s;
      en_regmult_r <= en_regmult_s;
      load_r       <= load_s;
      ms_sel_r     <= ms_sel_s;
      en_reg2_r    <= en_reg2_s;
      ack_r        <= ack_s;
      busy_r       <= busy_s;
    end
  end

  assign EN_REG1    = en_reg1_r;
  assign EN_REGmult = en_regmult_r;
  assign LOAD       = load_r;
  // Encd is held stable during DECIDE, so a direct compare is safe here.
  assign MS_1       = ms_sel_r & (Encd != SHIFT_REF_V);
  assign EN_REG2    = en_reg2_r;
  assign ACK_FF     = ack_r;
  assign BUSY       = busy_r;

endmodule

// File: tb/tb_fsm_convert_fixed_to_float.sv
// Directed bench for fsm_convert_fixed_to_float: checks every output each cycle
// against hand-decoded per-state vectors.
module tb_fsm_convert_fixed_to_float;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       BEGIN_FSM = 1'b0;
  logic [7:0] Encd = 8'd0;
  logic       Bandcomp = 1'b0;
  logic EN_REG1, EN_REGmult, LOAD, MS_1, EN_REG2, ACK_FF, BUSY;

  int n_chk  = 0;
  int n_fail = 0;

  // Output vector order: {EN_REG1, EN_REGmult, LOAD, MS_1, EN_REG2, ACK_FF, BUSY}
  localparam logic [6:0] V_IDLE  = 7'h00;
  localparam logic [6:0] V_LF    = 7'h41;
  localparam logic [6:0] V_DN    = 7'h21;
  localparam logic [6:0] V_ENC   = 7'h01;
  localparam logic [6:0] V_DEC0  = 7'h11;
  localparam logic [6:0] V_DEC1  = 7'h19;
  localparam logic [6:0] V_SH    = 7'h01;
  localparam logic [6:0] V_ST    = 7'h05;
  localparam logic [6:0] V_DONE  = 7'h03;

  fsm_convert_fixed_to_float #(.W(8), .SHIFT_REF(26)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .BEGIN_FSM  (BEGIN_FSM),
    .Encd       (Encd),
    .Bandcomp   (Bandcomp),
    .EN_REG1    (EN_REG1),
    .EN_REGmult (EN_REGmult),
    .LOAD       (LOAD),
    .MS_1       (MS_1),
    .EN_REG2    (EN_REG2),
    .ACK_FF     (ACK_FF),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {EN_REG1, EN_REGmult, LOAD, MS_1, EN_REG2, ACK_FF, BUSY};
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One full conversion starting from IDLE; BEGIN_FSM drops after LOAD_FIXED unless hold=1.
  task automatic conv(input string tag, input logic [7:0] e, input logic bc,
                      input logic ms, input logic hold);
    BEGIN_FSM = 1'b1;
    Encd      = e;
    Bandcomp  = bc;
    tick(); chk({tag, "_lf"}, V_LF);
    if (!hold) BEGIN_FSM = 1'b0;
    tick(); chk({tag, "_dn"}, V_DN);
    tick(); chk({tag, "_enc"}, V_ENC);
    tick(); chk({tag, "_dec"}, ms ? V_DEC1 : V_DEC0);
    tick(); chk({tag, "_sh"}, V_SH);
    tick(); chk({tag, "_st"}, V_ST);
    tick(); chk({tag, "_done"}, V_DONE);
  endtask

  initial begin
    // Reset held with BEGIN_FSM high
    RST = 1'b1;
    BEGIN_FSM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("rst_hold", V_IDLE);
    end
    // Release: first conversion, Encd=30 > 26
    RST = 1'b0;
    conv("nom30", 8'd30, 1'b1, 1'b1, 1'b0);
    tick(); chk("nom30_idle", V_IDLE);
    tick(); chk("nom30_idle2", V_IDLE);

    // Encd equal to reference: no shift
    conv("eq26", 8'd26, 1'b0, 1'b0, 1'b0);
    tick(); chk("eq26_idle", V_IDLE);

    // Encd below reference
    conv("lt10", 8'd10, 1'b0, 1'b1, 1'b0);
    tick(); chk("lt10_idle", V_IDLE);

    // BEGIN_FSM held high for 20 cycles: one conversion, ACK held
    conv("hold", 8'd40, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 13; i++) begin
      tick(); chk("hold_done", V_DONE);
    end
    BEGIN_FSM = 1'b0;
    tick(); chk("hold_idle", V_IDLE);
    conv("hold2", 8'd40, 1'b1, 1'b1, 1'b0);
    tick(); chk("hold2_idle", V_IDLE);

    // Reset in DECIDE aborts the conversion
    BEGIN_FSM = 1'b1;
    Encd = 8'd30;
    tick(); chk("abort_lf", V_LF);
    BEGIN_FSM = 1'b0;
    tick(); chk("abort_dn", V_DN);
    tick(); chk("abort_enc", V_ENC);
    tick(); chk("abort_dec", V_DEC1);
    RST = 1'b1;
    tick(); chk("abort_rst", V_IDLE);
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); chk("abort_quiet", V_IDLE);
    end
    conv("after_abort", 8'd5, 1'b0, 1'b1, 1'b0);
    tick(); chk("after_abort_idle", V_IDLE);

    // Encd toggling outside DECIDE, held at 26 through DECIDE
    BEGIN_FSM = 1'b1;
    Encd = 8'h00;
    tick(); chk("tog_lf", V_LF);
    BEGIN_FSM = 1'b0;
    Encd = 8'hFF;
    tick(); chk("tog_dn", V_DN);
    Encd = 8'h00;
    tick(); chk("tog_enc", V_ENC);
    Encd = 8'd26;
    tick(); chk("tog_dec", V_DEC0);
    Encd = 8'hFF;
    tick(); chk("tog_sh", V_SH);
    Encd = 8'h00;
    tick(); chk("tog_st", V_ST);
    Encd = 8'hFF;
    tick(); chk("tog_done", V_DONE);
    Encd = 8'h00;
    tick(); chk("tog_idle", V_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
